// File: rtl/mem_access_wb_pkg.sv
// Shared widths, writeback-source encodings and FSM states for the M-stage
// memory access / M->W pipeline register slice.
package mem_access_wb_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    REGSRC_ALU  = 2'b00,
    REGSRC_LOAD = 2'b01,
    REGSRC_LINK = 2'b10
  } regsrc_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb.sv
// M->W pipeline register; a stall inserts a bubble (write enable dropped)
// while the remaining W fields keep their previous values.
module mem_wb
  import mem_access_wb_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  we_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [WIDTH-1:0]      data_in,
  input  logic [WIDTH-1:0]      pc_in,
  output logic                  we_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [WIDTH-1:0]      data_out,
  output logic [WIDTH-1:0]      pc_out
);

  logic                  we_q,   we_d;
  logic [REG_ADDR_W-1:0] rd_q,   rd_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      pc_q,   pc_d;

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (!stall) begin
      we_d   = we_in;
      rd_d   = rd_in;
      data_d = data_in;
      pc_d   = pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      pc_q   <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  assign we_out   = we_q;
  assign rd_out   = rd_q;
  assign data_out = data_q;
  assign pc_out   = pc_q;

endmodule

// File: rtl/mem_access_wb.sv
// M-stage data-memory handshake FSM with ack timeout, writeback source mux,
// and the M->W register (mem_wb).
module mem_access_wb
  import mem_access_wb_pkg::*;
#(
  parameter int unsigned WIDTH   = WORD_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Regfile_weM,
  input  logic                  DataMem_weM,
  input  logic [REG_ADDR_W-1:0] writeRegAddrM,
  input  logic [1:0]            regSrc_muxM,
  input  logic [WIDTH-1:0]      aluOutM,
  input  logic [WIDTH-1:0]      writeDataM,
  input  logic [WIDTH-1:0]      pcM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WIDTH-1:0]      dmem_addr,
  output logic [WIDTH-1:0]      dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [WIDTH-1:0]      dmem_rdata,
  output logic                  stallM,
  output logic                  Regfile_weW,
  output logic [REG_ADDR_W-1:0] writeRegAddrW,
  output logic [WIDTH-1:0]      regWriteDataW,
  output logic [WIDTH-1:0]      pcW,
  output logic                  mem_err
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    dmem_req_q, dmem_req_d;
  logic                    dmem_we_q, dmem_we_d;
  logic [WIDTH-1:0]        dmem_addr_q, dmem_addr_d;
  logic [WIDTH-1:0]        dmem_wdata_q, dmem_wdata_d;
  logic                    mem_err_q, mem_err_d;

  logic                    memop;
  logic                    busy;
  logic                    timeout;
  logic                    done;
  logic                    wb_we;
  logic [WIDTH-1:0]        wb_data;

  // An ack arriving in the timeout cycle wins: the access completes normally.
  always_comb begin
    memop   = DataMem_weM || (regSrc_muxM == REGSRC_LOAD);
    busy    = (state_q == ST_BUSY);
    timeout = busy && !dmem_ack && (wait_cnt_q == TIMEOUT_CNT);
    done    = busy && (dmem_ack || timeout);
    stallM  = memop && !done;
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    mem_err_d    = mem_err_q || timeout;
    case (state_q)
      ST_IDLE: begin
        if (memop) begin
          state_d      = ST_BUSY;
          wait_cnt_d   = '0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = DataMem_weM;
          dmem_addr_d  = aluOutM;
          dmem_wdata_d = writeDataM;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d    = ST_IDLE;
          dmem_req_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (regSrc_muxM)
      REGSRC_LOAD: wb_data = dmem_rdata;
      REGSRC_LINK: wb_data = pcM + WIDTH'(4);
      default:     wb_data = aluOutM;
    endcase
    wb_we = Regfile_weM;
    if (timeout) begin
      wb_we   = 1'b0;
      wb_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign mem_err    = mem_err_q;

  mem_wb #(
    .WIDTH(WIDTH)
  ) u_mem_wb (
    .clk     (clk),
    .rst     (rst),
    .stall   (stallM),
    .we_in   (wb_we),
    .rd_in   (writeRegAddrM),
    .data_in (wb_data),
    .pc_in   (pcM),
    .we_out  (Regfile_weW),
    .rd_out  (writeRegAddrW),
    .data_out(regWriteDataW),
    .pc_out  (pcW)
  );

endmodule

// File: tb/tb_mem_access_wb.sv
// Directed bench: expected W-stage writes are queued at issue time and a
// negedge monitor pops and compares each Regfile_weW pulse.
module tb_mem_access_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        Regfile_weM;
  logic        DataMem_weM;
  logic [4:0]  writeRegAddrM;
  logic [1:0]  regSrc_muxM;
  logic [31:0] aluOutM;
  logic [31:0] writeDataM;
  logic [31:0] pcM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stallM;
  logic        Regfile_weW;
  logic [4:0]  writeRegAddrW;
  logic [31:0] regWriteDataW;
  logic [31:0] pcW;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_t;

  wb_t exp_q[$];

  always #5 clk = ~clk;

  mem_access_wb #(
    .WIDTH  (32),
    .TIMEOUT(5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Regfile_weM  (Regfile_weM),
    .DataMem_weM  (DataMem_weM),
    .writeRegAddrM(writeRegAddrM),
    .regSrc_muxM  (regSrc_muxM),
    .aluOutM      (aluOutM),
    .writeDataM   (writeDataM),
    .pcM          (pcM),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stallM       (stallM),
    .Regfile_weW  (Regfile_weW),
    .writeRegAddrW(writeRegAddrW),
    .regWriteDataW(regWriteDataW),
    .pcW          (pcW),
    .mem_err      (mem_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
    wb_t e;
    e.rd = rd; e.data = data; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Regfile_weM   = 1'b0;
    DataMem_weM   = 1'b0;
    writeRegAddrM = '0;
    regSrc_muxM   = 2'b00;
    aluOutM       = '0;
    writeDataM    = '0;
    pcM           = '0;
  endtask

  task automatic drive(input logic we, input logic st, input logic [4:0] rd, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc);
    Regfile_weM   = we;
    DataMem_weM   = st;
    writeRegAddrM = rd;
    regSrc_muxM   = src;
    aluOutM       = alu;
    writeDataM    = wd;
    pcM           = pc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dmem_req"},   {31'd0, dmem_req}, 32'd0);
    check({tag, "_dmem_we"},    {31'd0, dmem_we}, 32'd0);
    check({tag, "_dmem_addr"},  dmem_addr, 32'd0);
    check({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    check({tag, "_we_w"},       {31'd0, Regfile_weW}, 32'd0);
    check({tag, "_rd_w"},       {27'd0, writeRegAddrW}, 32'd0);
    check({tag, "_data_w"},     regWriteDataW, 32'd0);
    check({tag, "_pc_w"},       pcW, 32'd0);
    check({tag, "_mem_err"},    {31'd0, mem_err}, 32'd0);
  endtask

  // Scoreboard monitor: every W write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (Regfile_weW === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: rd=%0d data=0x%08h pc=0x%08h with nothing expected",
                 writeRegAddrW, regWriteDataW, pcW);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (writeRegAddrW !== e.rd || regWriteDataW !== e.data || pcW !== e.pc) begin
          n_fail++;
          $display("FAIL wb_write: got rd=%0d data=0x%08h pc=0x%08h expected rd=%0d data=0x%08h pc=0x%08h",
                   writeRegAddrW, regWriteDataW, pcW, e.rd, e.data, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    rst        = 1'b1;
    step();
    step();
    check_all_zero("reset");
    check("reset_stall", {31'd0, stallM}, 32'd0);
    rst = 1'b0;

    // ALU op, regSrc 00
    drive(1'b1, 1'b0, 5'd5, 2'b00, 32'h0000_1234, 32'h0, 32'h0000_1000);
    #1 check("alu_stall", {31'd0, stallM}, 32'd0);
    expect_wb(5'd5, 32'h0000_1234, 32'h0000_1000);
    step();
    check("alu_data_w", regWriteDataW, 32'h0000_1234);

    // ALU op, regSrc 11
    drive(1'b1, 1'b0, 5'd7, 2'b11, 32'hCAFE_0001, 32'h0, 32'h0000_1004);
    #1 check("alu11_stall", {31'd0, stallM}, 32'd0);
    expect_wb(5'd7, 32'hCAFE_0001, 32'h0000_1004);
    step();

    // Link with pc wrap
    drive(1'b1, 1'b0, 5'd31, 2'b10, 32'h0000_0055, 32'h0, 32'hFFFF_FFFC);
    #1 check("link_stall", {31'd0, stallM}, 32'd0);
    expect_wb(5'd31, 32'h0000_0000, 32'hFFFF_FFFC);
    step();
    check("link_wrap_data_w", regWriteDataW, 32'h0000_0000);

    // Link without wrap
    drive(1'b1, 1'b0, 5'd1, 2'b10, 32'h0, 32'h0, 32'h0000_0100);
    expect_wb(5'd1, 32'h0000_0104, 32'h0000_0100);
    step();

    // Ack in IDLE is ignored
    idle_inputs();
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("idle_ack_req", {31'd0, dmem_req}, 32'd0);
    check("idle_ack_we_w", {31'd0, Regfile_weW}, 32'd0);

    // Load at 0x100, ack in the 4th BUSY cycle
    drive(1'b1, 1'b0, 5'd9, 2'b01, 32'h0000_0100, 32'h1234_5678, 32'h0000_2000);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("load_stall", {31'd0, stallM}, 32'd1);
      if (i > 0) begin
        check("load_req_held", {31'd0, dmem_req}, 32'd1);
        check("load_addr_held", dmem_addr, 32'h0000_0100);
        check("load_we", {31'd0, dmem_we}, 32'd0);
        check("load_bubble", {31'd0, Regfile_weW}, 32'd0);
      end
      step();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1 check("load_ack_stall", {31'd0, stallM}, 32'd0);
    check("load_ack_addr", dmem_addr, 32'h0000_0100);
    expect_wb(5'd9, 32'hDEAD_BEEF, 32'h0000_2000);
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    idle_inputs();
    check("load_req_drop", {31'd0, dmem_req}, 32'd0);
    check("load_data_w", regWriteDataW, 32'hDEAD_BEEF);
    step();
    check("load_single_pulse", {31'd0, Regfile_weW}, 32'd0);

    // Store at 0x40, ack in first BUSY cycle
    drive(1'b0, 1'b1, 5'd0, 2'b00, 32'h0000_0040, 32'hA5A5_A5A5, 32'h0000_2100);
    #1 check("store_stall_idle", {31'd0, stallM}, 32'd1);
    step();
    check("store_req", {31'd0, dmem_req}, 32'd1);
    check("store_we", {31'd0, dmem_we}, 32'd1);
    check("store_addr", dmem_addr, 32'h0000_0040);
    check("store_wdata", dmem_wdata, 32'hA5A5_A5A5);
    dmem_ack = 1'b1;
    #1 check("store_ack_stall", {31'd0, stallM}, 32'd0);
    step();
    dmem_ack = 1'b0;
    check("store_req_drop", {31'd0, dmem_req}, 32'd0);
    check("store_we_w", {31'd0, Regfile_weW}, 32'd0);

    // Back-to-back: load starts its IDLE cycle right after the store's ack
    drive(1'b1, 1'b0, 5'd3, 2'b01, 32'h0000_0084, 32'h0, 32'h0000_3000);
    #1 check("b2b_idle_stall", {31'd0, stallM}, 32'd1);
    check("b2b_idle_req", {31'd0, dmem_req}, 32'd0);
    step();
    check("b2b_req", {31'd0, dmem_req}, 32'd1);
    check("b2b_addr", dmem_addr, 32'h0000_0084);
    check("b2b_we", {31'd0, dmem_we}, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1122_3344;
    expect_wb(5'd3, 32'h1122_3344, 32'h0000_3000);
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    idle_inputs();
    step();

    // Load with no ack: TIMEOUT=5 waiting cycles then the timeout cycle
    drive(1'b1, 1'b0, 5'd4, 2'b01, 32'h0000_0200, 32'h0, 32'h0000_4000);
    #1;
    for (int i = 0; i < 6; i++) begin
      check("to_stall", {31'd0, stallM}, 32'd1);
      check("to_err_early", {31'd0, mem_err}, 32'd0);
      step();
    end
    check("to_release", {31'd0, stallM}, 32'd0);
    step();
    idle_inputs();
    check("to_mem_err", {31'd0, mem_err}, 32'd1);
    check("to_req_drop", {31'd0, dmem_req}, 32'd0);
    check("to_we_w", {31'd0, Regfile_weW}, 32'd0);
    check("to_data_w", regWriteDataW, 32'd0);
    check("to_pc_w", pcW, 32'h0000_4000);
    repeat (3) step();
    check("to_err_sticky", {31'd0, mem_err}, 32'd1);
    drive(1'b1, 1'b0, 5'd2, 2'b00, 32'h0000_0077, 32'h0, 32'h0000_5000);
    expect_wb(5'd2, 32'h0000_0077, 32'h0000_5000);
    step();
    idle_inputs();
    check("to_err_sticky2", {31'd0, mem_err}, 32'd1);

    // Reset in the 2nd BUSY cycle, then a stray ack
    drive(1'b1, 1'b0, 5'd6, 2'b01, 32'h0000_0300, 32'h0, 32'h0000_6000);
    step();
    step();
    check("rb_busy_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    #1;
    check_all_zero("rb");
    check("rb_stall", {31'd0, stallM}, 32'd0);
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    check("rb_ack_req", {31'd0, dmem_req}, 32'd0);
    check("rb_ack_we_w", {31'd0, Regfile_weW}, 32'd0);
    drive(1'b1, 1'b0, 5'd8, 2'b00, 32'h0000_0088, 32'h0, 32'h0000_7000);
    #1 check("rb_after_stall", {31'd0, stallM}, 32'd0);
    expect_wb(5'd8, 32'h0000_0088, 32'h0000_7000);
    step();
    idle_inputs();
    repeat (2) step();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wb_missing: %0d expected writes never seen, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
